// File: rtl/conv_seq.sv
// conv_seq: layer sequencer for the 5x5 convolution datapath (DRAM addressing, load/accumulate strobes).
// Optional header legality check and err port: define CONV_SEQ_PARAM_CHECK_EN.
module conv_seq #(
    parameter int                    DATA_WIDTH = 32,
    parameter int                    ADDR_WIDTH = 18,
    parameter logic [ADDR_WIDTH-1:0] PARAM_ADDR = 18'd0,
    parameter logic [ADDR_WIDTH-1:0] KNL_BASE   = 18'd1,
    parameter logic [ADDR_WIDTH-1:0] IFMAP_BASE = 18'd8192,
    parameter logic [ADDR_WIDTH-1:0] OFMAP_BASE = 18'd65536
) (
    input  logic                  clk,
    input  logic                  srstn,
    input  logic                  enable,
    input  logic                  dram_valid,
    input  logic [DATA_WIDTH-1:0] data_in,
    output logic [ADDR_WIDTH-1:0] addr_in,
    output logic [ADDR_WIDTH-1:0] addr_out,
    output logic                  dram_en_rd,
    output logic                  dram_en_wr,
    output logic                  en_ld_knl,
    output logic                  en_ld_ifmap,
    output logic                  disable_acc,
    output logic [5:0]            num_knls,
    output logic [4:0]            cnt_ofmap_chnl,
    output logic                  done
`ifdef CONV_SEQ_PARAM_CHECK_EN
    ,
    output logic                  err
`endif
);

    typedef enum logic [2:0] {
        S_IDLE, S_HDR, S_KNL, S_WIN, S_CALC, S_PSUM, S_WR, S_DONE
    } state_t;

    localparam logic [ADDR_WIDTH-1:0] ONE_A = ADDR_WIDTH'(1);

    state_t                state_q;
    logic [5:0]            n_q, w_q, o_q;
    logic [4:0]            cn_q, c_q;
    logic [5:0]            r_q, col_q, k_q;
    logic [2:0]            i_q, j_q;
    logic [10:0]           knl_total_q, knl_cnt_q;
    logic [ADDR_WIDTH-1:0] ww_q, oo_q;
    logic [ADDR_WIDTH-1:0] addr_in_q, knl_addr_q;
    logic [ADDR_WIDTH-1:0] chnl_base_q, row_base_q, win_base_q, col_addr_q;
    logic [ADDR_WIDTH-1:0] opix_q, ofm_addr_q;
    logic                  done_q;
`ifdef CONV_SEQ_PARAM_CHECK_EN
    logic                  err_q;
`endif

    // Header field decode, evaluated while the header word is on data_in
    logic [5:0]            hdr_n, hdr_w, hdr_o;
    logic [4:0]            hdr_c;
    logic [10:0]           knl_total_d;
    logic [ADDR_WIDTH-1:0] ww_d, oo_d;
    logic                  unused_hdr_bits;

    assign hdr_n       = data_in[5:0];
    assign hdr_w       = data_in[13:8];
    assign hdr_c       = data_in[20:16];
    assign hdr_o       = hdr_w - 6'd4;
    assign knl_total_d = 11'({hdr_n, 4'b0000}) + 11'({hdr_n, 3'b000}) + 11'(hdr_n);
    assign ww_d        = ADDR_WIDTH'(hdr_w) * ADDR_WIDTH'(hdr_w);
    assign oo_d        = ADDR_WIDTH'(hdr_o) * ADDR_WIDTH'(hdr_o);
    assign unused_hdr_bits = ^{data_in[DATA_WIDTH-1:21], data_in[15:14], data_in[7:6]};

`ifdef CONV_SEQ_PARAM_CHECK_EN
    logic hdr_bad;
    assign hdr_bad = (hdr_n == 6'd0) || (hdr_n > 6'd16) || (hdr_w < 6'd5) ||
                     (hdr_w > 6'd32) || (hdr_c == 5'd0);
`endif

    logic                  last_k, last_col, last_row, last_c, last_knl;
    logic [ADDR_WIDTH-1:0] row_next_d, win_next_d;

    assign last_k     = (k_q == n_q - 6'd1);
    assign last_col   = (col_q == o_q - 6'd1);
    assign last_row   = (r_q == o_q - 6'd1);
    assign last_c     = (c_q == cn_q - 5'd1);
    assign last_knl   = (knl_cnt_q == knl_total_q - 11'd1);
    assign row_next_d = row_base_q + ADDR_WIDTH'(w_q);
    assign win_next_d = win_base_q + ONE_A;

    always_ff @(posedge clk) begin
        if (!srstn) begin
            state_q     <= S_IDLE;
            n_q         <= '0;
            w_q         <= '0;
            o_q         <= '0;
            cn_q        <= '0;
            c_q         <= '0;
            r_q         <= '0;
            col_q       <= '0;
            k_q         <= '0;
            i_q         <= '0;
            j_q         <= '0;
            knl_total_q <= '0;
            knl_cnt_q   <= '0;
            ww_q        <= '0;
            oo_q        <= '0;
            addr_in_q   <= '0;
            knl_addr_q  <= '0;
            chnl_base_q <= '0;
            row_base_q  <= '0;
            win_base_q  <= '0;
            col_addr_q  <= '0;
            opix_q      <= '0;
            ofm_addr_q  <= '0;
            done_q      <= 1'b0;
`ifdef CONV_SEQ_PARAM_CHECK_EN
            err_q       <= 1'b0;
`endif
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (enable) begin
                        state_q   <= S_HDR;
                        addr_in_q <= PARAM_ADDR;
                    end
                end
                S_HDR: begin
                    if (dram_valid) begin
                        n_q         <= hdr_n;
                        w_q         <= hdr_w;
                        o_q         <= hdr_o;
                        cn_q        <= hdr_c;
                        ww_q        <= ww_d;
                        oo_q        <= oo_d;
                        knl_total_q <= knl_total_d;
                        c_q         <= '0;
                        k_q         <= '0;
                        knl_cnt_q   <= '0;
                        chnl_base_q <= IFMAP_BASE;
                        knl_addr_q  <= KNL_BASE;
                        addr_in_q   <= KNL_BASE;
`ifdef CONV_SEQ_PARAM_CHECK_EN
                        if (hdr_bad) begin
                            state_q <= S_DONE;
                            done_q  <= 1'b1;
                            err_q   <= 1'b1;
                        end else begin
                            state_q <= S_KNL;
                        end
`else
                        state_q     <= S_KNL;
`endif
                    end
                end
                S_KNL: begin
                    // Kernel words for all channels are contiguous, so one pointer walks them all
                    if (dram_valid) begin
                        addr_in_q  <= addr_in_q + ONE_A;
                        knl_addr_q <= addr_in_q + ONE_A;
                        if (last_knl) begin
                            knl_cnt_q  <= '0;
                            state_q    <= S_WIN;
                            r_q        <= '0;
                            col_q      <= '0;
                            i_q        <= '0;
                            j_q        <= '0;
                            row_base_q <= chnl_base_q;
                            win_base_q <= chnl_base_q;
                            col_addr_q <= chnl_base_q;
                            addr_in_q  <= chnl_base_q;
                            opix_q     <= OFMAP_BASE;
                        end else begin
                            knl_cnt_q <= knl_cnt_q + 11'd1;
                        end
                    end
                end
                S_WIN: begin
                    // Column-major walk: step down a row by W, then jump to top of next column
                    if (dram_valid) begin
                        if (i_q == 3'd4) begin
                            i_q <= '0;
                            if (j_q == 3'd4) begin
                                j_q        <= '0;
                                k_q        <= '0;
                                ofm_addr_q <= opix_q;
                                state_q    <= S_CALC;
                            end else begin
                                j_q        <= j_q + 3'd1;
                                col_addr_q <= col_addr_q + ONE_A;
                                addr_in_q  <= col_addr_q + ONE_A;
                            end
                        end else begin
                            i_q       <= i_q + 3'd1;
                            addr_in_q <= addr_in_q + ADDR_WIDTH'(w_q);
                        end
                    end
                end
                S_CALC: begin
                    if (c_q == 5'd0) begin
                        state_q <= S_WR;
                    end else begin
                        state_q   <= S_PSUM;
                        addr_in_q <= ofm_addr_q;
                    end
                end
                S_PSUM, S_WR: begin
                    // The PSUM accept cycle doubles as the write-back cycle
                    if ((state_q == S_WR) || dram_valid) begin
                        if (!last_k) begin
                            k_q        <= k_q + 6'd1;
                            ofm_addr_q <= ofm_addr_q + oo_q;
                            state_q    <= S_CALC;
                        end else if (!last_col) begin
                            col_q      <= col_q + 6'd1;
                            win_base_q <= win_next_d;
                            col_addr_q <= win_next_d;
                            addr_in_q  <= win_next_d;
                            opix_q     <= opix_q + ONE_A;
                            state_q    <= S_WIN;
                        end else if (!last_row) begin
                            r_q        <= r_q + 6'd1;
                            col_q      <= '0;
                            row_base_q <= row_next_d;
                            win_base_q <= row_next_d;
                            col_addr_q <= row_next_d;
                            addr_in_q  <= row_next_d;
                            opix_q     <= opix_q + ONE_A;
                            state_q    <= S_WIN;
                        end else if (!last_c) begin
                            c_q         <= c_q + 5'd1;
                            chnl_base_q <= chnl_base_q + ww_q;
                            addr_in_q   <= knl_addr_q;
                            state_q     <= S_KNL;
                        end else begin
                            state_q <= S_DONE;
                            done_q  <= 1'b1;
                        end
                    end
                end
                S_DONE: begin
                    if (!enable) begin
                        state_q <= S_IDLE;
                        done_q  <= 1'b0;
`ifdef CONV_SEQ_PARAM_CHECK_EN
                        err_q   <= 1'b0;
`endif
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    logic active;
    assign active = (state_q == S_KNL) || (state_q == S_WIN) || (state_q == S_CALC) ||
                    (state_q == S_PSUM) || (state_q == S_WR);

    assign dram_en_rd     = (state_q == S_HDR) || (state_q == S_KNL) ||
                            (state_q == S_WIN) || (state_q == S_PSUM);
    assign dram_en_wr     = (state_q == S_WR) || ((state_q == S_PSUM) && dram_valid);
    assign en_ld_knl      = (state_q == S_KNL) && dram_valid;
    assign en_ld_ifmap    = (state_q == S_WIN) && dram_valid;
    assign disable_acc    = active && (c_q == 5'd0);
    assign addr_in        = addr_in_q;
    assign addr_out       = ofm_addr_q;
    assign num_knls       = n_q;
    assign cnt_ofmap_chnl = k_q[4:0];
    assign done           = done_q;
`ifdef CONV_SEQ_PARAM_CHECK_EN
    assign err            = err_q;
`endif

endmodule

// File: tb/tb_conv_seq.sv
// Scoreboard bench for conv_seq: a loop-nest model predicts every DRAM read/write event.
`timescale 1ns/1ps
module tb_conv_seq;
    localparam int AW = 18;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          srstn = 1'b0;
    logic          enable = 1'b0;
    logic          dram_valid = 1'b0;
    logic [DW-1:0] data_in = '0;
    logic [AW-1:0] addr_in, addr_out;
    logic          dram_en_rd, dram_en_wr, en_ld_knl, en_ld_ifmap, disable_acc, done;
    logic [5:0]    num_knls;
    logic [4:0]    cnt_ofmap_chnl;
    logic          err_s;

    always #5 clk = ~clk;

`ifdef CONV_SEQ_PARAM_CHECK_EN
    logic err;
    assign err_s = err;
`else
    assign err_s = 1'b0;
`endif

    conv_seq dut (
        .clk(clk), .srstn(srstn), .enable(enable), .dram_valid(dram_valid), .data_in(data_in),
        .addr_in(addr_in), .addr_out(addr_out), .dram_en_rd(dram_en_rd), .dram_en_wr(dram_en_wr),
        .en_ld_knl(en_ld_knl), .en_ld_ifmap(en_ld_ifmap), .disable_acc(disable_acc),
        .num_knls(num_knls), .cnt_ofmap_chnl(cnt_ofmap_chnl), .done(done)
`ifdef CONV_SEQ_PARAM_CHECK_EN
        , .err(err)
`endif
    );

    // Event tuple: {is_write, addr, ld_knl|0, ld_ifmap|disable_acc, k|0}
    typedef logic [25:0] ev_t;

    int          total = 0;
    int          bad = 0;
    ev_t         exp_q[$];
    bit          mon_en = 1'b0;
    bit          spur_en = 1'b1;
    int          max_delay = 0;
    int          ifmap_beats = 0;
    logic [31:0] hdr_word = '0;

    function automatic ev_t rd_ev(input logic [AW-1:0] a, input logic lk, input logic li);
        return {1'b0, a, lk, li, 5'd0};
    endfunction

    function automatic ev_t wr_ev(input logic [AW-1:0] a, input logic dis, input logic [4:0] k);
        return {1'b1, a, 1'b0, dis, k};
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s got=%h exp=%h t=%0t", nm, act, req, $time);
        end
    endtask

    task automatic pop_cmp(input ev_t act);
        ev_t e;
        if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_event got=%h exp=none t=%0t", act, $time);
        end else begin
            e = exp_q.pop_front();
            chk("event", 64'(act), 64'(e));
        end
    endtask

    // DRAM read responder: random latency per request, spurious valids while idle
    initial begin : responder
        int wait_cnt;
        bit gave;
        wait_cnt = 0;
        gave = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (gave) wait_cnt = $urandom_range(0, max_delay);
            gave = 1'b0;
            dram_valid = 1'b0;
            if (dram_en_rd) begin
                if (wait_cnt == 0) begin
                    dram_valid = 1'b1;
                    gave = 1'b1;
                    data_in = (addr_in == 18'd0) ? hdr_word : $urandom;
                end else begin
                    wait_cnt--;
                end
            end else if (spur_en && ($urandom_range(0, 3) == 0)) begin
                dram_valid = 1'b1;
                data_in = $urandom;
            end
        end
    end

    // Monitor: pops the scoreboard on every accepted read and every write strobe
    initial begin : monitor
        bit            pend;
        logic [AW-1:0] pend_addr;
        pend = 1'b0;
        pend_addr = '0;
        forever begin
            @(negedge clk);
            if (mon_en) begin
                if (pend) chk("addr_hold", 64'({dram_en_rd, addr_in}), 64'({1'b1, pend_addr}));
                if (dram_en_rd && dram_valid) pop_cmp(rd_ev(addr_in, en_ld_knl, en_ld_ifmap));
                else chk("ld_idle", 64'({en_ld_knl, en_ld_ifmap}), 64'd0);
                if (dram_en_wr) pop_cmp(wr_ev(addr_out, disable_acc, cnt_ofmap_chnl));
                if (en_ld_ifmap) ifmap_beats++;
                pend = dram_en_rd && !dram_valid;
                pend_addr = addr_in;
            end else begin
                pend = 1'b0;
            end
        end
    end

    task automatic set_header(input int n, input int w, input int c);
        hdr_word = $urandom;
        hdr_word[5:0] = 6'(n);
        hdr_word[13:8] = 6'(w);
        hdr_word[20:16] = 5'(c);
    endtask

    // Reference: plain loop nest over channels, window positions and output channels
    task automatic build_expected(input int n, input int w, input int c);
        int o;
        logic [AW-1:0] a;
        o = w - 4;
        exp_q.delete();
        exp_q.push_back(rd_ev(18'd0, 1'b0, 1'b0));
        for (int ch = 0; ch < c; ch++) begin
            for (int t = 0; t < n * 25; t++) exp_q.push_back(rd_ev(AW'(1 + ch * n * 25 + t), 1'b1, 1'b0));
            for (int r = 0; r < o; r++) begin
                for (int col = 0; col < o; col++) begin
                    for (int j = 0; j < 5; j++)
                        for (int i = 0; i < 5; i++)
                            exp_q.push_back(rd_ev(AW'(8192 + ch * w * w + (r + i) * w + col + j), 1'b0, 1'b1));
                    for (int k = 0; k < n; k++) begin
                        a = AW'(65536 + k * o * o + r * o + col);
                        if (ch > 0) exp_q.push_back(rd_ev(a, 1'b0, 1'b0));
                        exp_q.push_back(wr_ev(a, (ch == 0), 5'(k)));
                    end
                end
            end
        end
    endtask

    task automatic check_reset_outputs(input string nm);
        chk(nm, 64'({addr_in, addr_out, dram_en_rd, dram_en_wr, en_ld_knl, en_ld_ifmap,
                     disable_acc, num_knls, cnt_ofmap_chnl, done, err_s}), 64'd0);
    endtask

    task automatic pulse_reset();
        mon_en = 1'b0;
        enable = 1'b0;
        srstn = 1'b0;
        repeat (2) @(negedge clk);
        srstn = 1'b1;
        exp_q.delete();
    endtask

    task automatic wait_done(output bit got, input bit drop);
        got = 1'b0;
        for (int t = 0; t < 30000 && !got; t++) begin
            @(negedge clk);
            if (drop && t == 40) enable = 1'b0;
            if (done) got = 1'b1;
        end
        if (!got) begin
            total++;
            bad++;
            $display("FAIL done_timeout got=0 exp=1");
        end
    endtask

    task automatic run_layer(input int n, input int w, input int c, input int maxd, input bit drop);
        bit got;
        set_header(n, w, c);
        max_delay = maxd;
        build_expected(n, w, c);
        ifmap_beats = 0;
        mon_en = 1'b1;
        @(negedge clk);
        enable = 1'b1;
        wait_done(got, drop);
        chk("events_left", 64'(exp_q.size()), 64'd0);
        chk("num_knls", 64'(num_knls), 64'(n));
        chk("ifmap_beats", 64'(ifmap_beats), 64'(25 * c * (w - 4) * (w - 4)));
        if (!drop) begin
            repeat (2) @(negedge clk);
            chk("done_hold", 64'({done, err_s}), 64'b10);
        end
        enable = 1'b0;
        repeat (2) @(negedge clk);
        chk("done_clear", 64'(done), 64'd0);
        if (!got) pulse_reset();
    endtask

`ifdef CONV_SEQ_PARAM_CHECK_EN
    task automatic run_bad(input int n, input int w, input int c);
        bit got;
        set_header(n, w, c);
        max_delay = 1;
        exp_q.delete();
        exp_q.push_back(rd_ev(18'd0, 1'b0, 1'b0));
        mon_en = 1'b1;
        @(negedge clk);
        enable = 1'b1;
        wait_done(got, 1'b0);
        chk("err_set", 64'({done, err_s}), 64'b11);
        chk("bad_events_left", 64'(exp_q.size()), 64'd0);
        repeat (3) @(negedge clk);
        chk("err_hold", 64'({done, err_s, dram_en_rd, dram_en_wr}), 64'b1100);
        enable = 1'b0;
        repeat (2) @(negedge clk);
        chk("err_clear", 64'({done, err_s}), 64'd0);
        if (!got) pulse_reset();
    endtask
`endif

    initial begin : stimulus
        bit got;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset_state");
        srstn = 1'b1;
        @(negedge clk);

        run_layer(1, 5, 1, 0, 1'b0);
        run_layer(2, 6, 2, 0, 1'b0);
        run_layer(2, 6, 2, 3, 1'b0);
        run_layer(1, 7, 1, 1, 1'b0);

        // Abort in the middle of channel-0 window streaming
        set_header(2, 6, 1);
        max_delay = 2;
        build_expected(2, 6, 1);
        ifmap_beats = 0;
        mon_en = 1'b1;
        @(negedge clk);
        enable = 1'b1;
        got = 1'b0;
        for (int t = 0; t < 5000 && !got; t++) begin
            @(negedge clk);
            if (ifmap_beats >= 10) got = 1'b1;
        end
        chk("reach_win", 64'(got), 64'd1);
        @(posedge clk);
        #2;
        mon_en = 1'b0;
        srstn = 1'b0;
        enable = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check_reset_outputs("reset_mid");
        repeat (2) @(negedge clk);
        chk("reset_quiet", 64'({dram_en_rd, dram_en_wr, done}), 64'd0);
        srstn = 1'b1;
        exp_q.delete();
        run_layer(2, 6, 1, 2, 1'b0);

        for (int it = 0; it < 3; it++)
            run_layer($urandom_range(1, 3), $urandom_range(5, 8), $urandom_range(1, 3), 3, (it == 2));

`ifdef CONV_SEQ_PARAM_CHECK_EN
        run_bad(17, 6, 1);
        run_bad(0, 6, 1);
        run_bad(2, 4, 1);
        run_bad(2, 33, 1);
        run_bad(2, 6, 0);
        run_layer(1, 5, 2, 1, 1'b0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/conv_seq.md
# conv_seq

Top-level sequencer for the 5x5 convolution datapath. It reads a layer header from DRAM and loads each input channel's kernel set into the datapath's weight shift register. It then streams 25-word input windows and, for every output channel, reads the partial sum, adds the MAC result and writes it back. It owns all DRAM addressing and read/write strobes and drives the datapath's load, accumulate-disable and output-channel selects.

## Interface
- DATA_WIDTH, 32, DRAM word width
- ADDR_WIDTH, 18, DRAM word-address width
- PARAM_ADDR, 18'd0, header word address
- KNL_BASE, 18'd1, first kernel word
- IFMAP_BASE, 18'd8192, input map base
- OFMAP_BASE, 18'd65536, output map base
- clk  in  1  clock
- srstn  in  1  reset, synchronous, active-low
- enable  in  1  start request, sampled only in IDLE
- dram_valid  in  1  read data valid on data_in this cycle
- data_in  in  DATA_WIDTH  DRAM read data (header decode only)
- addr_in  out  ADDR_WIDTH  DRAM read address
- addr_out  out  ADDR_WIDTH  DRAM write address
- dram_en_rd  out  1  read request
- dram_en_wr  out  1  write strobe
- en_ld_knl  out  1  shift data_in into weight file
- en_ld_ifmap  out  1  shift data_in into window file
- disable_acc  out  1  write MAC only, no partial-sum add
- num_knls  out  6  output channels, from header
- cnt_ofmap_chnl  out  5  current output channel
- done  out  1  layer complete
- err  out  1  illegal header (only with CONV_SEQ_PARAM_CHECK_EN)

## Operation
- Header word: [5:0] num_knls N (1..16), [13:8] map width W (5..32), [20:16] input channels C (1..16). Output width O = W-4.
- States:
  - IDLE: go to HDR when enable=1.
  - HDR: read PARAM_ADDR, latch fields, go to KNL.
  - KNL: read N*25 words sequentially from KNL_BASE + c*N*25; assert en_ld_knl on each valid beat.
  - WIN: read 25 window words in column-major order. Word j*5+i = IFMAP_BASE + c*W*W + (r+i)*W + (col+j), for column j and row i; assert en_ld_ifmap per beat.
  - CALC: drive cnt_ofmap_chnl=k for one cycle.
  - PSUM: c>0 only. Read OFMAP_BASE + k*O*O + r*O + col.
  - WR: write that same address.
  - DONE.
- CALC→WR when c=0, else CALC→PSUM.
- After WR: k+1 → CALC. When k=N-1: next col, then next row, → WIN. Row O-1 done: c+1 → KNL. c=C-1 done → DONE.
- DONE: done=1 until enable=0, then IDLE.
- disable_acc = (c==0).
- Address arithmetic is incremental counters, truncated to ADDR_WIDTH.

## Timing
- Reset: all outputs 0, state IDLE, counters and latched header 0. Reset mid-run aborts immediately; no further strobes.
- Read handshake: dram_en_rd and addr_in are held until the cycle dram_valid=1. data_in is consumed in that cycle, and the next request may issue the following cycle. dram_valid while dram_en_rd=0 is ignored.
- en_ld_knl / en_ld_ifmap equal dram_valid in KNL/WIN: exactly one shift per accepted word.
- cnt_ofmap_chnl is stable from CALC through WR; the datapath registers the MAC one cycle after CALC.
- c=0: dram_en_wr pulses one cycle, in the cycle after CALC.
- c>0: dram_en_wr is asserted in the same cycle PSUM sees dram_valid (data_out = data_in + mac), then CALC next cycle.
- Writes never stall.
- dram_en_rd and dram_en_wr are never high together, except the PSUM accept cycle.
- enable dropping mid-run is ignored.

## Configuration
- CONV_SEQ_PARAM_CHECK_EN defined:
  - The err port exists. A header with N=0, N>16, W<5, W>32 or C=0 goes HDR→DONE with err=1 and no reads or writes beyond the header.
  - err clears when leaving DONE.
- Not defined: no err port; header used unchecked.

## Test plan
- Header N=1,W=5,C=1, ramp data -> 1+25+25 reads, exactly one write to OFMAP_BASE, disable_acc=1, done after write.
- N=2,W=6,C=2 -> 8 writes per channel (O=2); channel 1 writes each preceded by PSUM read of same address with disable_acc=0; kernel reads start at KNL_BASE+50.
- dram_valid delayed 0..3 random cycles per read -> addr_in stable while waiting; en_ld counts exactly 25N and 25 per window.
- srstn low during WIN of channel 0 -> next cycle all outputs 0, state IDLE; rerun completes normally.
- Header N=17 with macro defined -> err=1, done=1, zero writes; enable low -> both clear.
- Window address order for W=7, r=1, col=2, c=0 -> first reads IFMAP_BASE+9, +16, +23, +30, +37, then +10.
